// File: rtl/cmp_sched.sv
// cmp_sched: two-port scheduler for the shared ALU comparator (IDLE -> EVAL -> RESP).
// Define CMP_SCHED_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module cmp_sched #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [OPW-1:0]   op0,
  input  logic [OPW-1:0]   op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             us0,
  input  logic             us1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags,
  output logic             wr_en,
  output logic             taken,
  output logic [OPW-1:0]   cmp_op,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic [WIDTH-1:0] cmp_res,
  input  logic [3:0]       cmp_flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_reg;
  logic   owner_reg;
  logic   us_q;
  logic   pick1;

`ifdef CMP_SCHED_FIXED_PRIO_EN
  assign pick1 = req1 & ~req0;
`else
  // last_reg = 1 means port 1 was served last, so port 0 wins the next tie
  logic last_reg;

  assign pick1 = req1 & (~req0 | ~last_reg);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_reg <= 1'b1;
    end else if (state_reg == RESP) begin
      last_reg <= owner_reg;
    end
  end
`endif

  function automatic logic wr_dec(input logic [OPW-1:0] op, input logic f0);
    logic w;
    w = 1'b0;
    if (op <= OPW'(5)) begin
      w = 1'b1;
    end else if (op == OPW'(6) || op == OPW'(13)) begin
      w = f0;
    end
    return w;
  endfunction

  function automatic logic taken_dec(input logic [OPW-1:0] op, input logic [3:0] f,
                                     input logic us);
    logic t;
    t = 1'b0;
    if (op >= OPW'(7) && op <= OPW'(12)) begin
      t = f[0];
    end else if (op == OPW'(14) || op == OPW'(15)) begin
      t = us ? f[3] : f[2];
    end
    return t;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      us_q      <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      busy      <= 1'b0;
      res       <= '0;
      flags     <= '0;
      wr_en     <= 1'b0;
      taken     <= 1'b0;
      cmp_op    <= '0;
      cmp_a     <= '0;
      cmp_b     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          if (req0 | req1) begin
            owner_reg <= pick1;
            gnt0      <= ~pick1;
            gnt1      <= pick1;
            busy      <= 1'b1;
            cmp_op    <= pick1 ? op1 : op0;
            cmp_a     <= pick1 ? a1  : a0;
            cmp_b     <= pick1 ? b1  : b0;
            us_q      <= pick1 ? us1 : us0;
            state_reg <= EVAL;
          end
        end
        EVAL: begin
          gnt0      <= 1'b0;
          gnt1      <= 1'b0;
          res       <= cmp_res;
          flags     <= cmp_flags;
          wr_en     <= wr_dec(cmp_op, cmp_flags[0]);
          taken     <= taken_dec(cmp_op, cmp_flags, us_q);
          done0     <= ~owner_reg;
          done1     <= owner_reg;
          state_reg <= RESP;
        end
        RESP: begin
          done0     <= 1'b0;
          done1     <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          gnt0      <= 1'b0;
          gnt1      <= 1'b0;
          done0     <= 1'b0;
          done1     <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_sched.sv
// tb_cmp_sched: directed + randomized checks of cmp_sched against a transaction-level model
// (arbitration by pending requests and last-served port, decisions from opcode rules).
module tb_cmp_sched;
  localparam int WIDTH = 32;
  localparam int OPW   = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [OPW-1:0] op0 = '0, op1 = '0;
  logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic us0 = 1'b0, us1 = 1'b0;
  logic gnt0, gnt1, done0, done1, busy, wr_en, taken;
  logic [WIDTH-1:0] res, cmp_a, cmp_b, cmp_res;
  logic [3:0] flags, cmp_flags;
  logic [OPW-1:0] cmp_op;

  int tests = 0;
  int fails = 0;
  int last_m = 1;
  bit pend0 = 1'b0, pend1 = 1'b0;

  cmp_sched #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .us0(us0), .us1(us1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .busy(busy),
    .res(res), .flags(flags), .wr_en(wr_en), .taken(taken),
    .cmp_op(cmp_op), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_res(cmp_res), .cmp_flags(cmp_flags)
  );

  always #5 clk = ~clk;

  // Comparator stand-in: {res[31:0], flags[3:0]}; flags = {ult, slt, res==0, condition}
  function automatic logic [35:0] cmp_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    logic [3:0]  f;
    logic        slt, ult, stop, want;
    int          cnt;
    slt = $signed(a) < $signed(b);
    ult = a < b;
    r = a - b;
    case (op)
      4'd0, 4'd2:  r = {31'd0, slt};
      4'd1, 4'd3:  r = {31'd0, ult};
      4'd4, 4'd5: begin
        want = (op == 4'd4);
        cnt = 0;
        stop = 1'b0;
        for (int i = 31; i >= 0; i--) begin
          if (!stop && a[i] == want) cnt++;
          else stop = 1'b1;
        end
        r = 32'(cnt);
      end
      4'd6, 4'd13: r = a;
      default: ;
    endcase
    case (op)
      4'd6:    f[0] = (b == 0);
      4'd13:   f[0] = (b != 0);
      4'd7:    f[0] = (a != b);
      4'd9:    f[0] = slt;
      4'd10:   f[0] = !slt;
      4'd11:   f[0] = ult;
      4'd12:   f[0] = !ult;
      default: f[0] = (a == b);
    endcase
    f[1] = (r == 0);
    f[2] = slt;
    f[3] = ult;
    return {r, f};
  endfunction

  always_comb {cmp_res, cmp_flags} = cmp_model(cmp_op, cmp_a, cmp_b);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      chk("gnt_excl", 64'(gnt0 & gnt1), 64'd0);
      chk("done_excl", 64'(done0 & done1), 64'd0);
    end
  end

  // Called at a negedge with the DUT idle and req lines reflecting pend0/pend1.
  task automatic serve();
    int w;
    logic [3:0]  eop;
    logic [31:0] ea, eb;
    logic        eus, ewr, etk;
    logic [35:0] m;
`ifdef CMP_SCHED_FIXED_PRIO_EN
    w = pend0 ? 0 : 1;
`else
    w = (pend0 && pend1) ? 1 - last_m : (pend0 ? 0 : 1);
`endif
    if (w == 0) begin eop = op0; ea = a0; eb = b0; eus = us0; end
    else        begin eop = op1; ea = a1; eb = b1; eus = us1; end
    m   = cmp_model(eop, ea, eb);
    ewr = (eop <= 4'd5) || ((eop == 4'd6 || eop == 4'd13) && m[0]);
    etk = (eop >= 4'd7 && eop <= 4'd12) ? m[0] :
          (eop >= 4'd14) ? (eus ? m[3] : m[2]) : 1'b0;
    @(negedge clk);
    chk("gnt0", 64'(gnt0), 64'(w == 0));
    chk("gnt1", 64'(gnt1), 64'(w == 1));
    chk("busy_eval", 64'(busy), 64'd1);
    chk("cmp_op", 64'(cmp_op), 64'(eop));
    chk("cmp_a", 64'(cmp_a), 64'(ea));
    chk("cmp_b", 64'(cmp_b), 64'(eb));
    if (w == 0) begin req0 = 1'b0; pend0 = 1'b0; end
    else        begin req1 = 1'b0; pend1 = 1'b0; end
    @(negedge clk);
    chk("done0", 64'(done0), 64'(w == 0));
    chk("done1", 64'(done1), 64'(w == 1));
    chk("gnt_resp", 64'({gnt0, gnt1}), 64'd0);
    chk("res", 64'(res), 64'(m[35:4]));
    chk("flags", 64'(flags), 64'(m[3:0]));
    chk("wr_en", 64'(wr_en), 64'(ewr));
    chk("taken", 64'(taken), 64'(etk));
    last_m = w;
    $display("[TB] txn port=%0d op=%0d a=%h b=%h us=%0b res=%h flags=%h wr_en=%0b taken=%0b",
             w, eop, ea, eb, eus, res, flags, wr_en, taken);
    @(negedge clk);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("done_idle", 64'({done0, done1}), 64'd0);
  endtask

  task automatic rand_port(input int p);
    logic [3:0]  o;
    logic [31:0] x, y;
    o = 4'($urandom);
    y = ($urandom_range(3, 0) == 0) ? 32'd0 : $urandom;
    x = ($urandom_range(3, 0) == 0) ? y : $urandom;
    if (p == 0) begin op0 = o; a0 = x; b0 = y; us0 = 1'($urandom); pend0 = 1'b1; req0 = 1'b1; end
    else        begin op1 = o; a1 = x; b1 = y; us1 = 1'($urandom); pend1 = 1'b1; req1 = 1'b1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int gcnt;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outs", 64'({gnt0, gnt1, done0, done1, busy, wr_en, taken}), 64'd0);
    chk("rst_res", 64'(res), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // SLT on port 1
    op1 = 4'd0; a1 = 32'd5; b1 = 32'd9; us1 = 1'b0; pend1 = 1'b1; req1 = 1'b1;
    serve();
    chk("t1_res", 64'(res), 64'd1);
    chk("t1_wr", 64'(wr_en), 64'd1);
    chk("t1_taken", 64'(taken), 64'd0);

    // Equality branch on port 0
    op0 = 4'd8; a0 = 32'h1234; b0 = 32'h1234; pend0 = 1'b1; req0 = 1'b1;
    serve();
    chk("t2_flag0", 64'(flags[0]), 64'd1);
    chk("t2_taken", 64'(taken), 64'd1);
    chk("t2_wr", 64'(wr_en), 64'd0);

    // TLTU-style trap with signed and unsigned select
    op0 = 4'd15; a0 = 32'hFFFF_FFFF; b0 = 32'd1; us0 = 1'b0; pend0 = 1'b1; req0 = 1'b1;
    serve();
    chk("t3_signed_taken", 64'(taken), 64'd1);
    us0 = 1'b1; pend0 = 1'b1; req0 = 1'b1;
    serve();
    chk("t3_unsigned_taken", 64'(taken), 64'd0);

    // MOVZ on port 1
    op1 = 4'd6; a1 = 32'hAA; b1 = 32'd0; pend1 = 1'b1; req1 = 1'b1;
    serve();
    chk("t4_res", 64'(res), 64'hAA);
    chk("t4_wr", 64'(wr_en), 64'd1);
    b1 = 32'd3; pend1 = 1'b1; req1 = 1'b1;
    serve();
    chk("t4_wr_nz", 64'(wr_en), 64'd0);

    // Both requests held for 12 cycles
    op0 = 4'd1; a0 = 32'd1; b0 = 32'd2; op1 = 4'd9; a1 = 32'd3; b1 = 32'd4;
    req0 = 1'b1; req1 = 1'b1;
    w = 0;
    gcnt = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc % 3 == 1) begin
`ifdef CMP_SCHED_FIXED_PRIO_EN
        w = 0;
`else
        w = 1 - last_m;
`endif
        last_m = w;
        gcnt++;
        $display("[TB] txn tie grant #%0d cycle=%0d expected_port=%0d gnt0=%0b gnt1=%0b",
                 gcnt, cyc, w, gnt0, gnt1);
      end
      chk("tie_gnt0", 64'(gnt0), 64'((cyc % 3 == 1) && w == 0));
      chk("tie_gnt1", 64'(gnt1), 64'((cyc % 3 == 1) && w == 1));
      chk("tie_done0", 64'(done0), 64'((cyc % 3 == 2) && w == 0));
      chk("tie_done1", 64'(done1), 64'((cyc % 3 == 2) && w == 1));
    end
    req0 = 1'b0; req1 = 1'b0;

    // Reset while in EVAL
    op0 = 4'd8; a0 = 32'd7; b0 = 32'd7; pend0 = 1'b1; req0 = 1'b1;
    @(negedge clk);
    chk("rst_eval_gnt0", 64'(gnt0), 64'd1);
    reset_n = 1'b0; req0 = 1'b0; pend0 = 1'b0;
    @(negedge clk);
    chk("rst_mid_ctl", 64'({gnt0, gnt1, done0, done1, busy, wr_en, taken}), 64'd0);
    chk("rst_mid_data", 64'({res, flags}), 64'd0);
    chk("rst_mid_cmp", 64'({cmp_op, cmp_a}), 64'd0);
    chk("rst_mid_cmpb", 64'(cmp_b), 64'd0);
    reset_n = 1'b1;
    last_m = 1;
    @(negedge clk);
    chk("rst_no_done", 64'({done0, done1, busy}), 64'd0);
    $display("[TB] txn reset during EVAL: outputs cleared, no done");
    rand_port(0);
    rand_port(1);
    serve();
    chk("rst_tie_last", 64'(last_m), 64'd0);
    serve();

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      if (!pend0 && $urandom_range(1, 0) == 1) rand_port(0);
      if (!pend1 && $urandom_range(1, 0) == 1) rand_port(1);
      if (!pend0 && !pend1) rand_port(int'($urandom_range(1, 0)));
      serve();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
